mc_controller: RTL

//  Multicycle MIPS control unit: main FSM plus ALU decoder, driving the multicycle datapath.

---
 rtl/mc_controller_pkg.sv | 54 +++++
 rtl/mc_controller_alu_decoder.sv | 39 +++
 rtl/mc_controller.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_controller_pkg.sv
// ----------------------------------------------------------------------------
// mc_controller_pkg : state, opcode, funct and ALU codes for mc_controller
// Rev 1.0 ; MC_CTRL_BNE_EN adds the bne opcode
// ----------------------------------------------------------------------------
`default_nettype none

package mc_controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_controller_alu_decoder.sv
// ----------------------------------------------------------------------------
// mc_alu_decoder : combinational alu_op/funct to alu_control mapping
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module mc_alu_decoder
  import mc_controller_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            alu_op_i,
  input  logic [5:0]            funct_i,
  output logic [ALU_CTRL_W-1:0] alu_control_o
);

  logic [2:0] code;

  always_comb begin
    code = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB: code = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_SUB:  code = ALU_SUB;
          FN_AND:  code = ALU_AND;
          FN_OR:   code = ALU_OR;
          FN_SLT:  code = ALU_SLT;
          default: code = ALU_ADD;
        endcase
      end
      default: code = ALU_ADD;
    endcase
    alu_control_o = ALU_CTRL_W'(code);
  end

endmodule

`default_nettype wire

// File: rtl/mc_controller.sv
// ----------------------------------------------------------------------------
// mc_controller : multicycle MIPS control FSM with memory handshake/watchdog
// Rev 1.0 ; define MC_CTRL_BNE_EN to support bne
// ----------------------------------------------------------------------------
`default_nettype none

module mc_controller
  import mc_controller_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter int WAIT_LIMIT = 15,
  parameter int WAIT_CNT_W = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [5:0]            opcode,
  input  logic [5:0]            funct,
  input  logic                  zero,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_write,
  output logic                  i_or_d,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  branch,
  output logic                  pc_en,
  output logic [1:0]            pc_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  reg_dst,
  output logic                  mem_to_reg,
  output logic                  reg_write,
  output logic                  illegal,
  output logic                  mem_timeout
);

  state_t                state_q, state_d;
  logic [WAIT_CNT_W-1:0] wait_q, wait_d;
  logic [1:0]            alu_op;
  logic [ALU_CTRL_W-1:0] alu_ctrl_raw;
  logic                  timeout;
  logic                  take;

  assign timeout = is_mem_state(state_q) && !mem_ready &&
                   (wait_q == WAIT_CNT_W'(WAIT_LIMIT));
  // Count only while a memory state is stalled; any move (or timeout) restarts it.
  assign wait_d  = (is_mem_state(state_q) && !mem_ready && !timeout) ?
                   wait_q + 1'b1 : '0;

`ifdef MC_CTRL_BNE_EN
  logic is_bne_q, is_bne_d;

  always_comb begin
    is_bne_d = is_bne_q;
    if (state_q == S_FETCH)       is_bne_d = 1'b0;
    else if (state_q == S_DECODE) is_bne_d = (opcode == OP_BNE);
  end

  always_ff @(posedge clk) begin
    if (!reset) is_bne_q <= 1'b0;
    else        is_bne_q <= is_bne_d;
  end

  assign take = zero ^ is_bne_q;
`else
  assign take = zero;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .alu_op_i      (alu_op),
    .funct_i       (funct),
    .alu_control_o (alu_ctrl_raw)
  );

  always_comb begin
    state_d     = state_q;
    alu_op      = ALUOP_ADD;
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    i_or_d      = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    pc_src      = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    reg_write   = 1'b0;
    illegal     = 1'b0;
    mem_timeout = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = S_BRANCH;
`endif
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JUMP;
          default: begin
            illegal = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        i_or_d  = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req   = 1'b1;
        i_or_d    = 1'b1;
        mem_write = 1'b1;
        if (mem_ready) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = 2'b01;
        branch    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        state_d  = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    if (timeout) begin
      mem_timeout = 1'b1;
      mem_write   = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      state_d     = S_FETCH;
    end
    pc_en = pc_write | (branch & take);
    // Reset silences every output, even mid-instruction.
    if (!reset) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      i_or_d      = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      branch      = 1'b0;
      pc_en       = 1'b0;
      pc_src      = 2'b00;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      reg_dst     = 1'b0;
      mem_to_reg  = 1'b0;
      reg_write   = 1'b0;
      illegal     = 1'b0;
      mem_timeout = 1'b0;
    end
  end

  assign alu_control = reset ? alu_ctrl_raw : '0;

endmodule

`default_nettype wire
